// File: rtl/press_counter_7seg.sv
// Counts presses of a debounced switch as two-digit BCD (00-99) and drives two seven-segment digits.
// Latency: o_Count 1 cycle after i_Switch rises, segments 2 cycles; o_Clear_Pulse aligned with o_Count=00.
// Backpressure: none; the switch level is sampled every cycle and never stalled.
//
// Ports:
//   i_Clk         system clock, all logic on posedge
//   i_Rst_L       synchronous active-low reset
//   i_Switch      debounced switch level, synchronous to i_Clk
//   o_Seg_Ones    ones digit segments, bit0=A..bit6=G, active-low
//   o_Seg_Tens    tens digit segments, same encoding; optionally dark while tens is 0
//   o_Count       BCD count, [7:4] tens, [3:0] ones
//   o_Clear_Pulse one-cycle high when a long hold clears the count
module press_counter_7seg #(
    parameter int HOLD_CYCLES        = 50000000,
    parameter bit BLANK_LEADING_ZERO = 1'b1
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Switch,
    output logic [6:0] o_Seg_Ones,
    output logic [6:0] o_Seg_Tens,
    output logic [7:0] o_Count,
    output logic       o_Clear_Pulse
);

    localparam int            TW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_MAX = {TW{1'b1}};
    localparam logic [6:0]    SEG_ZERO  = 7'b1000000;
    localparam logic [6:0]    SEG_DARK  = 7'b1111111;
    localparam logic [6:0]    TENS_RST  = BLANK_LEADING_ZERO ? SEG_DARK : SEG_ZERO;

    typedef enum logic [1:0] {IDLE, HELD, CLEARED} state_t;

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [7:0]    count_q;
    logic          switch_q;
    logic          clear_q;
    logic [6:0]    seg_ones_q, seg_tens_q;
    logic [6:0]    seg_ones_d, seg_tens_d;
    logic          rise;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // Two-digit BCD increment; 99 wraps quietly to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] c);
        logic [3:0] tens, ones;
        tens = c[7:4];
        ones = c[3:0];
        if (ones == 4'd9) begin
            ones = 4'd0;
            tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            ones = ones + 4'd1;
        end
        bcd_inc = {tens, ones};
    endfunction

    always_comb begin
        rise       = ~switch_q & i_Switch;
        seg_ones_d = seg_decode(count_q[3:0]);
        seg_tens_d = (BLANK_LEADING_ZERO && count_q[7:4] == 4'd0) ? SEG_DARK
                                                                  : seg_decode(count_q[7:4]);
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            count_q    <= 8'h00;
            switch_q   <= 1'b0;
            clear_q    <= 1'b0;
            seg_ones_q <= SEG_ZERO;
            seg_tens_q <= TENS_RST;
        end else begin
            switch_q   <= i_Switch;
            clear_q    <= 1'b0;
            seg_ones_q <= seg_ones_d;
            seg_tens_q <= seg_tens_d;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        count_q <= bcd_inc(count_q);
                        timer_q <= TW'(1);
                        state_q <= HELD;
                    end
                end
                HELD: begin
                    if (!i_Switch) begin
                        timer_q <= '0;
                        state_q <= IDLE;
                    end else if (timer_q == HOLD_LAST) begin
                        // Clear fires on the HOLD_CYCLES-th consecutive high sample.
                        count_q <= 8'h00;
                        clear_q <= 1'b1;
                        timer_q <= '0;
                        state_q <= CLEARED;
                    end else if (timer_q != TIMER_MAX) begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                CLEARED: begin
                    // Wait out the hold; the release is not a press.
                    if (!i_Switch) begin
                        timer_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    timer_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_Seg_Ones    = seg_ones_q;
    assign o_Seg_Tens    = seg_tens_q;
    assign o_Count       = count_q;
    assign o_Clear_Pulse = clear_q;

endmodule

// File: tb/tb_press_counter_7seg.sv
// Directed bench for press_counter_7seg with HOLD_CYCLES=16 and blanked leading zero.
module tb_press_counter_7seg;

    logic       clk;
    logic       rst_l;
    logic       sw;
    logic [6:0] seg_ones, seg_tens;
    logic [7:0] count;
    logic       clr;

    int n_cmp  = 0;
    int n_bad  = 0;
    int clr_cnt = 0;
    int clr_base;

    press_counter_7seg #(.HOLD_CYCLES(16), .BLANK_LEADING_ZERO(1'b1)) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_l),
        .i_Switch     (sw),
        .o_Seg_Ones   (seg_ones),
        .o_Seg_Tens   (seg_tens),
        .o_Count      (count),
        .o_Clear_Pulse(clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each clear pulse lasts one cycle, so it is seen at exactly one negedge.
    always @(negedge clk) if (clr) clr_cnt++;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int hi, input int lo);
        sw = 1'b1;
        repeat (hi) step();
        sw = 1'b0;
        repeat (lo) step();
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        sw    = 1'b0;
        repeat (3) step();
        rst_l = 1'b1;
    endtask

    initial begin
        rst_l = 1'b0;
        sw    = 1'b0;

        // Reset state
        do_reset();
        step();
        chk("rst_count", count, 8'h00);
        chk("rst_ones", {1'b0, seg_ones}, 8'b01000000);
        chk("rst_tens", {1'b0, seg_tens}, 8'b01111111);
        chk("rst_clr", {7'b0, clr}, 8'h00);

        // First press: count after 1 cycle, segments after 2
        sw = 1'b1;
        step();
        chk("lat_count1", count, 8'h01);
        chk("lat_seg_old", {1'b0, seg_ones}, 8'b01000000);
        step();
        chk("lat_seg_new", {1'b0, seg_ones}, 8'b01111001);
        repeat (2) step();
        sw = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 6; i++) press(4, 4);
        chk("p7_count", count, 8'h07);
        chk("p7_ones", {1'b0, seg_ones}, 8'b01111000);
        chk("p7_tens", {1'b0, seg_tens}, 8'b01111111);

        // 100 back-to-back single-cycle presses: rollover and silent wrap
        do_reset();
        step();
        clr_base = clr_cnt;
        for (int i = 1; i <= 100; i++) begin
            press(1, 1);
            if (i == 9)  chk("c09", count, 8'h09);
            if (i == 10) begin
                chk("c10", count, 8'h10);
                chk("c10_tens", {1'b0, seg_tens}, 8'b01111001);
                chk("c10_ones", {1'b0, seg_ones}, 8'b01000000);
            end
            if (i == 99) begin
                chk("c99", count, 8'h99);
                chk("c99_ones", {1'b0, seg_ones}, 8'b00010000);
                chk("c99_tens", {1'b0, seg_tens}, 8'b00010000);
            end
        end
        chk("wrap_count", count, 8'h00);
        chk("wrap_tens_dark", {1'b0, seg_tens}, 8'b01111111);
        chk("wrap_no_clr", 8'(clr_cnt - clr_base), 8'h00);

        // Hold clear from 25
        for (int i = 0; i < 25; i++) press(1, 1);
        chk("c25", count, 8'h25);
        clr_base = clr_cnt;
        sw = 1'b1;
        step();
        chk("hold_rise", count, 8'h26);
        repeat (14) step();
        chk("hold15_count", count, 8'h26);
        chk("hold15_clr", {7'b0, clr}, 8'h00);
        step();
        chk("hold16_count", count, 8'h00);
        chk("hold16_clr", {7'b0, clr}, 8'h01);
        step();
        chk("hold17_clr", {7'b0, clr}, 8'h00);
        repeat (3) step();
        sw = 1'b0;
        repeat (2) step();
        chk("release_count", count, 8'h00);
        press(1, 1);
        chk("after_clr_press", count, 8'h01);
        chk("one_clr_pulse", 8'(clr_cnt - clr_base), 8'h01);

        // Hold 15 cycles then release: no clear
        clr_base = clr_cnt;
        press(15, 2);
        chk("hold15_rel_count", count, 8'h02);
        chk("hold15_rel_noclr", 8'(clr_cnt - clr_base), 8'h00);

        // Reset mid-hold with the switch still high
        sw = 1'b1;
        repeat (10) step();
        chk("midhold_count", count, 8'h03);
        rst_l = 1'b0;
        step();
        chk("midrst_count", count, 8'h00);
        chk("midrst_ones", {1'b0, seg_ones}, 8'b01000000);
        rst_l = 1'b1;
        clr_base = clr_cnt;
        step();
        chk("postrst_rise", count, 8'h01);
        repeat (14) step();
        chk("postrst_15_count", count, 8'h01);
        chk("postrst_15_noclr", 8'(clr_cnt - clr_base), 8'h00);
        step();
        chk("postrst_16_count", count, 8'h00);
        chk("postrst_16_clr", {7'b0, clr}, 8'h01);
        repeat (3) step();
        sw = 1'b0;
        repeat (2) step();
        chk("cleared_release", count, 8'h00);
        chk("postrst_one_clr", 8'(clr_cnt - clr_base), 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/press_counter_7seg.md
Name: press_counter_7seg

Overview:
Downstream consumer of the debounced switch level on the Go-board style LED/switch path. Counts rising edges (presses) of the debounced switch as a two-digit BCD value 00-99 and drives two active-low seven-segment digits. A press held for HOLD_CYCLES clears the count to 00. Input is already debounced; this block performs no filtering.

Parameters:
HOLD_CYCLES, 50000000, continuous high cycles that trigger a clear (2 s at 25 MHz); legal range is 2 or more.
BLANK_LEADING_ZERO, 1, 1 = tens digit dark while tens is 0; 0 = tens digit shows "0".

Ports:
i_Clk  input  1  system clock; all logic on posedge.
i_Rst_L  input  1  reset; synchronous, active-low.
i_Switch  input  1  debounced switch level, synchronous to i_Clk.
o_Seg_Ones  output  7  ones digit segments; bit0=A through bit6=G; active-low (0 = lit).
o_Seg_Tens  output  7  tens digit segments; same encoding as o_Seg_Ones.
o_Count  output  8  BCD count; [7:4] = tens, [3:0] = ones.
o_Clear_Pulse  output  1  one-cycle high when a hold-clear executes.

Behaviour:
- Reset (i_Rst_L=0 at posedge):
  - count = 00, FSM = IDLE, hold timer = 0, switch history register = 0, o_Clear_Pulse = 0.
  - o_Seg_Ones = 7'b1000000 ("0").
  - o_Seg_Tens = 7'b1111111 if BLANK_LEADING_ZERO, else 7'b1000000.
  - Reset has priority over every other event, including mid-hold. After reset the history register is 0, so a switch already high produces one rising edge on the first active cycle.
- Edge detect: r_Switch <= i_Switch every cycle. Rise = (r_Switch==0 && i_Switch==1).
- FSM states: IDLE, HELD, CLEARED.
  - IDLE: on rise, increment count and go to HELD with timer = 1.
  - HELD: while i_Switch=1, timer increments. When timer reaches HOLD_CYCLES-1 and i_Switch is still 1, count <= 00, o_Clear_Pulse = 1 for that cycle, go to CLEARED. If i_Switch=0, go to IDLE and reset the timer.
  - CLEARED: ignore i_Switch=1. On i_Switch=0, go to IDLE. The release never increments the count.
- Increment: BCD.
  - ones 9 -> 0 with tens+1.
  - 99 -> 00 wraps silently, with no clear pulse.
  - Count is updated only on a rise in IDLE and on a clear in HELD.
- Timer width is clog2(HOLD_CYCLES+1). It saturates and never wraps.
- Latency:
  - o_Count changes on the posedge where the rise is sampled, so it is visible 1 cycle after i_Switch goes high.
  - Segment outputs are registered decodes of count, one further cycle (2 cycles from input).
  - o_Clear_Pulse asserts in the same cycle o_Count becomes 00.
- Segment codes (active-low, G..A): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any illegal BCD nibble decodes to 1111111 (dark).
- Glitches: a one-cycle high pulse counts as one press, because the input is trusted as debounced. Back-to-back rises separated by one low cycle each count.

Test Plan:
- Reset held 3 cycles with i_Switch=0, then released -> o_Count=8'h00, o_Seg_Ones=7'b1000000, o_Seg_Tens=7'b1111111, o_Clear_Pulse=0.
- 7 presses (4 cycles high, 4 low; HOLD_CYCLES=16) -> o_Count=8'h07, o_Seg_Ones=7'b1111000, tens dark. o_Count updates 1 cycle and segments 2 cycles after each rise.
- 100 short presses -> o_Count passes through 09->10, shows 99 (ones=tens=7'b0010000), then wraps to 00 with no o_Clear_Pulse.
- Count at 8'h25, then hold high 20 cycles (HOLD_CYCLES=16):
  - First rise -> 8'h26.
  - On hold cycle 16 -> o_Count=8'h00 and o_Clear_Pulse=1 for exactly 1 cycle.
  - Release -> count stays 00, and the next press gives 01.
- Hold 15 cycles, then release (HOLD_CYCLES=16) -> no clear, o_Count stays at incremented value.
- i_Rst_L=0 asserted mid-hold at timer=10 with i_Switch held high, then reset released -> count 00, FSM IDLE; a rise is detected on the first active cycle, so o_Count=01 and no clear unless the hold then lasts 16 more cycles.
